// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, FSM encoding and address-split helpers for the data cache
// Ports: none (package). Direct-mapped cache: tag = addr[31:8], index = addr[7:4], word = addr[3:2].
package dcache_pkg;

    localparam int NUM_LINES  = 16;
    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int TAG_W      = 32 - IDX_W - 4;
    localparam int LINE_BITS  = 128;
    localparam int WSEL_W     = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESUME    = 2'd3
    } state_e;

    // Plain vector constants so the state register stays an ordinary logic vector.
    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_WRITEBACK = WRITEBACK;
    localparam logic [1:0] ST_REFILL    = REFILL;
    localparam logic [1:0] ST_RESUME    = RESUME;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return TAG_W'(addr >> (32 - TAG_W));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'(addr >> 4);
    endfunction

    function automatic logic [WSEL_W-1:0] addr_wsel(input logic [31:0] addr);
        return WSEL_W'(addr >> 2);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU-side and memory-side signal bundle of the data cache
// slave modport: the cache (receives CPU requests, initiates memory line transfers).
// master modport: the environment (MEM stage plus backing memory).
interface dcache_if;
    import dcache_pkg::*;

    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [31:0]          cpu_addr_i;
    logic [31:0]          cpu_wdata_i;
    logic [31:0]          cpu_rdata_o;
    logic                 cpu_stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic [LINE_BITS-1:0] mem_rdata_i;
    logic                 mem_ack_i;
    logic [31:0]          hit_cnt_o;
    logic [31:0]          miss_cnt_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output hit_cnt_o, miss_cnt_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/dcache_line_array.sv
// rtl/dcache_line_array.sv - valid/dirty/tag/data storage for the direct-mapped cache
// Ports: clk_i, rst_i (sync, active-high, clears valid/dirty only);
//   asynchronous read of one line (rd_idx -> rd_valid/rd_dirty/rd_tag/rd_data);
//   single write port at wr_idx: wr_line=1 installs a refilled line (valid, clean, new tag),
//   wr_line=0 writes one word and marks the line dirty.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic                 wr_line,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [WSEL_W-1:0]    wr_wsel,
    input  logic [31:0]          wr_word,
    input  logic [LINE_BITS-1:0] wr_line_data
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_BITS-1:0] lines [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = lines[rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            if (wr_line) begin
                valid[wr_idx] <= 1'b1;
                dirty[wr_idx] <= 1'b0;
            end else begin
                dirty[wr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            if (wr_line) begin
                tags[wr_idx]  <= wr_tag;
                lines[wr_idx] <= wr_line_data;
            end else begin
                lines[wr_idx][32*wr_wsel +: 32] <= wr_word;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
// Ports: clk_i, rst_i (sync, active-high); bus (dcache_if.slave): CPU word access with
//   combinational hit/stall, line-granular memory initiator (req held until ack), hit/miss counters.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    dcache_if.slave bus
);

    logic [1:0]           state;
    logic [TAG_W-1:0]     lat_tag;
    logic [IDX_W-1:0]     lat_idx;
    logic [31:0]          hit_cnt;
    logic [31:0]          miss_cnt;

    logic [TAG_W-1:0]     cpu_tag;
    logic [IDX_W-1:0]     cpu_idx;
    logic [WSEL_W-1:0]    cpu_wsel;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 in_idle;
    logic                 idle_hit;
    logic                 idle_miss;
    logic                 wr_en;
    logic                 wr_line;

    assign cpu_tag  = addr_tag(bus.cpu_addr_i);
    assign cpu_idx  = addr_idx(bus.cpu_addr_i);
    assign cpu_wsel = addr_wsel(bus.cpu_addr_i);

    // Outside IDLE the array is addressed by the latched miss index, so the victim line and
    // tag seen by the memory side stay stable however the CPU address moves.
    assign in_idle   = (state == ST_IDLE);
    assign rd_idx    = in_idle ? cpu_idx : lat_idx;
    assign idle_hit  = in_idle & bus.cpu_req_i & rd_valid & (rd_tag == cpu_tag);
    assign idle_miss = in_idle & bus.cpu_req_i & ~idle_hit;

    assign wr_line = (state == ST_REFILL);
    assign wr_en   = (idle_hit & bus.cpu_we_i) | (wr_line & bus.mem_ack_i);

    dcache_line_array u_lines (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_idx       (rd_idx),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_line      (wr_line),
        .wr_idx       (rd_idx),
        .wr_tag       (lat_tag),
        .wr_wsel      (cpu_wsel),
        .wr_word      (bus.cpu_wdata_i),
        .wr_line_data (bus.mem_rdata_i)
    );

    assign bus.cpu_stall_o = ~in_idle | idle_miss;
    assign bus.cpu_rdata_o = (idle_hit & ~bus.cpu_we_i) ? rd_data[32*cpu_wsel +: 32] : 32'd0;

    // Memory side depends only on registered state and latched fields.
    assign bus.mem_req_o   = (state == ST_WRITEBACK) | (state == ST_REFILL);
    assign bus.mem_we_o    = (state == ST_WRITEBACK);
    assign bus.mem_addr_o  = (state == ST_WRITEBACK) ? {rd_tag, lat_idx, 4'b0000} :
                             (state == ST_REFILL)    ? {lat_tag, lat_idx, 4'b0000} : 32'd0;
    assign bus.mem_wdata_o = (state == ST_WRITEBACK) ? rd_data : '0;

    assign bus.hit_cnt_o  = hit_cnt;
    assign bus.miss_cnt_o = miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            lat_tag  <= '0;
            lat_idx  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_hit) begin
                        hit_cnt <= hit_cnt + 32'd1;
                    end else if (idle_miss) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        lat_tag  <= cpu_tag;
                        lat_idx  <= cpu_idx;
                        state    <= (rd_valid & rd_dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
                ST_WRITEBACK: if (bus.mem_ack_i) state <= ST_REFILL;
                ST_REFILL:    if (bus.mem_ack_i) state <= ST_RESUME;
                // The held request is re-evaluated in IDLE, where it now hits and is counted.
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;

    logic clk = 1'b0;
    logic rst;

    dcache_if bus();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Backing memory and responder state
    int          ack_delay;
    int          stray_req;
    int          stray_done;
    int          stab_err;
    logic [31:0] bk_word [logic [31:0]];
    logic        log_we [$];
    logic [31:0] log_addr [$];
    logic [127:0] log_wdata [$];

    // Reference model: flat word memory plus line residency per index
    logic [31:0] ref_word [logic [31:0]];
    int          res_line [16];
    bit          res_dirty [16];
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA5A5_0000;
        return a * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [31:0] bk_rd(input logic [31:0] a);
        if (bk_word.exists(a)) return bk_word[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_word.exists(a)) return ref_word[a];
        return init_word(a);
    endfunction

    // Memory responder: acks each request after ack_delay cycles of mem_req_o.
    initial begin
        logic [31:0]  cap_addr;
        logic         cap_we;
        logic [127:0] cap_wdata;
        int           age;
        age = 0;
        cap_addr = '0;
        cap_we = 1'b0;
        cap_wdata = '0;
        stray_done = 0;
        stab_err = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i = 1'b0;
            if (rst) begin
                age = 0;
            end else if (bus.mem_req_o === 1'b1) begin
                if (age == 0) begin
                    cap_we = bus.mem_we_o;
                    cap_addr = bus.mem_addr_o;
                    cap_wdata = bus.mem_wdata_o;
                    log_we.push_back(cap_we);
                    log_addr.push_back(cap_addr);
                    log_wdata.push_back(cap_wdata);
                end else if (bus.mem_we_o !== cap_we || bus.mem_addr_o !== cap_addr ||
                             bus.mem_wdata_o !== cap_wdata) begin
                    stab_err++;
                end
                age++;
                if (age >= ack_delay) begin
                    for (int k = 0; k < 4; k++) begin
                        if (cap_we) bk_word[cap_addr + 32'(4*k)] = cap_wdata[32*k +: 32];
                        else bus.mem_rdata_i[32*k +: 32] = bk_rd(cap_addr + 32'(4*k));
                    end
                    bus.mem_ack_i = 1'b1;
                    age = 0;
                end
            end else begin
                age = 0;
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    bus.mem_rdata_i = {4{32'hDEAD_BEEF}};
                    bus.mem_ack_i = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            res_line[i] = -1;
            res_dirty[i] = 1'b0;
        end
        ref_word = bk_word;  // dirty lines not yet written back are lost
        exp_hit = 0;
        exp_miss = 0;
    endtask

    task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input int d, output int exp_stall, output logic [31:0] exp_rdata);
        logic [31:0] wa;
        int idx;
        int line;
        wa = addr & ~32'h3;
        idx = int'(addr[7:4]);
        line = int'(addr >> 4);
        exp_stall = 0;
        if (res_line[idx] != line) begin
            exp_miss++;
            exp_stall = (res_line[idx] >= 0 && res_dirty[idx]) ? 2*d + 2 : d + 2;
            res_line[idx] = line;
            res_dirty[idx] = 1'b0;
        end
        exp_hit++;
        exp_rdata = 32'd0;
        if (we) begin
            ref_word[wa] = wd;
            res_dirty[idx] = 1'b1;
        end else begin
            exp_rdata = ref_rd(wa);
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the completing edge.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int stalls, output logic [31:0] rdata);
        int guard;
        bus.cpu_req_i = 1'b1;
        bus.cpu_we_i = we;
        bus.cpu_addr_i = addr;
        bus.cpu_wdata_i = wd;
        stalls = 0;
        guard = 0;
        #1;
        while (bus.cpu_stall_o === 1'b1 && guard < 200) begin
            stalls++;
            guard++;
            @(posedge clk);
            #3;
        end
        rdata = bus.cpu_rdata_o;
        @(posedge clk);
        #2;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i = 1'b0;
    endtask

    task automatic step(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int es;
        int st;
        logic [31:0] er;
        logic [31:0] r;
        model_step(we, addr, wd, ack_delay, es, er);
        run_access(we, addr, wd, st, r);
        check({tag, "_stall"}, st, es);
        if (!we) check({tag, "_rdata"}, r, er);
        check({tag, "_hit_cnt"}, bus.hit_cnt_o, exp_hit);
        check({tag, "_miss_cnt"}, bus.miss_cnt_o, exp_miss);
    endtask

    initial begin
        int log0;
        int wbs;
        int g;
        logic [31:0] a;
        rst = 1'b1;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_wdata_i = '0;
        ack_delay = 3;
        stray_req = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", bus.cpu_stall_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_wdata", bus.mem_wdata_o, 0);
        check("rst_rdata", bus.cpu_rdata_o, 0);
        check("rst_hit_cnt", bus.hit_cnt_o, 0);
        check("rst_miss_cnt", bus.miss_cnt_o, 0);
        rst = 1'b0;

        // Clean miss, refill acked after 3 cycles
        ack_delay = 3;
        log0 = log_we.size();
        step("ld100", 1'b0, 32'h0000_0100, 32'd0);
        wbs = 0;
        for (int k = log0; k < log_we.size(); k++) if (log_we[k]) wbs++;
        check("ld100_no_mem_we", wbs, 0);
        check("ld100_req_count", log_we.size() - log0, 1);
        if (log_addr.size() > log0) check("ld100_fetch_addr", log_addr[log0], 32'h0000_0100);

        step("st104", 1'b1, 32'h0000_0104, 32'h1234_5678);
        step("ld104", 1'b0, 32'h0000_0104, 32'd0);

        // Conflicting load on dirty index 0
        ack_delay = 2;
        log0 = log_we.size();
        step("ld1104", 1'b0, 32'h0000_1104, 32'd0);
        check("ld1104_req_count", log_we.size() - log0, 2);
        if (log_we.size() >= log0 + 2) begin
            check("wb_we", log_we[log0], 1);
            check("wb_addr", log_addr[log0], 32'h0000_0100);
            check("wb_word1", log_wdata[log0][63:32], 32'h1234_5678);
            check("rf_we", log_we[log0+1], 0);
            check("rf_addr", log_addr[log0+1], 32'h0000_1100);
        end

        // Stray ack while idle
        stray_req++;
        repeat (3) @(posedge clk);
        #2;
        check("stray_hit_cnt", bus.hit_cnt_o, exp_hit);
        check("stray_miss_cnt", bus.miss_cnt_o, exp_miss);
        check("stray_mem_req", bus.mem_req_o, 0);
        check("stray_stall", bus.cpu_stall_o, 0);
        step("ld1104_again", 1'b0, 32'h0000_1104, 32'd0);

        // Random traffic over three tags to exercise conflicts and write-backs
        for (int i = 0; i < 200; i++) begin
            a = {22'd0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            ack_delay = $urandom_range(1, 4);
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset mid-refill
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        check("rst2_hit_cnt", bus.hit_cnt_o, 0);
        check("rst2_miss_cnt", bus.miss_cnt_o, 0);
        ack_delay = 6;
        bus.cpu_req_i = 1'b1;
        bus.cpu_we_i = 1'b0;
        bus.cpu_addr_i = 32'h2000_0040;
        g = 0;
        while (!(bus.mem_req_o === 1'b1) && g < 20) begin
            @(posedge clk);
            #2;
            g++;
        end
        check("midrf_mem_req", bus.mem_req_o, 1);
        check("midrf_mem_we", bus.mem_we_o, 0);
        check("midrf_mem_addr", bus.mem_addr_o, 32'h2000_0040);
        rst = 1'b1;
        bus.cpu_req_i = 1'b0;
        @(posedge clk);
        #2;
        check("midrf_rst_mem_req", bus.mem_req_o, 0);
        check("midrf_rst_stall", bus.cpu_stall_o, 0);
        rst = 1'b0;
        stray_req++;
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        ack_delay = 2;
        step("reaccess", 1'b0, 32'h2000_0040, 32'd0);

        // Hit counter wrap
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt;
        exp_hit = 32'hFFFF_FFFF;
        step("wrap", 1'b0, 32'h2000_0040, 32'd0);

        check("mem_side_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (load/store initiator) and a slow line-based backing memory. It answers CPU word accesses, on a hit in the same cycle, and stalls the pipeline on a miss. During a miss it acts as initiator on the memory side: write back the dirty victim, refill the line, then complete the access. It also keeps hit and miss counters for performance runs.

Parameters:
NUM_LINES, 16, number of cache lines; power of 2; index width IDX_W = log2(NUM_LINES).
LINE_WORDS, 4, 32-bit words per line; line = 128 bits; offset bits [3:0].
TAG_W, 24, tag width = 32 - IDX_W - 4.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite)
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address; bits [1:0] ignored (word access only)
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data; valid when cpu_req_i & !cpu_stall_o
cpu_stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
mem_req_o  out  1  memory request; held high until mem_ack_i
mem_we_o  out  1  1 = line write-back, 0 = line fetch
mem_addr_o  out  32  line-aligned address; [3:0] = 0
mem_wdata_o  out  128  victim line data
mem_rdata_i  in  128  fetched line; sampled on mem_ack_i
mem_ack_i  in  1  single-cycle completion pulse
hit_cnt_o  out  32  completed hit accesses; wraps
miss_cnt_o  out  32  misses detected; wraps

Behaviour:
- Address split: tag = addr[31:8], index = addr[7:4], word select = addr[3:2].
- Per line: valid, dirty, tag, 128-bit data.
- Reset (rst_i high at clk edge):
  - all valid and dirty bits cleared; state = IDLE; both counters = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, cpu_stall_o = 0, cpu_rdata_o = 0.
  - Reset mid-transaction drops mem_req_o on the next cycle. A later mem_ack_i is ignored.
- hit = cpu_req_i & valid[index] & (tag[index] == tag).
- IDLE:
  - Load hit: cpu_rdata_o = selected word, combinational, 0 cycles. Stall low. hit_cnt +1 at the edge.
  - Store hit: word written at the edge; dirty[index] = 1; stall low; hit_cnt +1.
  - Miss: cpu_stall_o high in the same cycle (combinational); miss_cnt +1.
    - victim valid & dirty -> WRITEBACK.
    - otherwise -> REFILL.
  - No request: stall low; cpu_rdata_o = 0.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_wdata_o = victim line. Stall high.
  - On mem_ack_i -> REFILL.
- REFILL:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, index, 4'b0}. Stall high.
  - On mem_ack_i: line = mem_rdata_i, valid = 1, dirty = 0, tag updated -> RESUME.
- RESUME:
  - Stall high for one cycle, then -> IDLE.
  - The held request now hits: one extra cycle of stall, and hit_cnt increments then.
- Latency:
  - clean miss: stall cycles = (cycles to REFILL ack) + 2.
  - dirty miss adds the write-back handshake.
- Memory-side outputs are decoded from the registered state and registered request fields (address and index latched on entry to the miss). They do not change while mem_req_o is high.
- mem_ack_i in IDLE or RESUME is ignored.
- cpu_req_i or cpu_addr_i changing mid-miss: the transaction completes using the latched address (no abort). Return to IDLE, then evaluate the new request.
- Line 0 and index NUM_LINES-1 behave identically; there is no index wrap special case.
- Counters wrap from 0xFFFFFFFF to 0.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, REFILL, RESUME}
  - constants NUM_LINES, LINE_WORDS, TAG_W, IDX_W, LINE_BITS = 128
  - helper functions for tag, index and word-select extraction.
- One sub-module, dcache_line_array: valid/dirty/tag/data storage with reset clear.
  - Read ports: asynchronous, for one index.
  - Write port: single, with full-line write or word write plus dirty set.
- The FSM, hit logic and counters stay in dcache_controller.

Test Plan:
- Reset, then load 0x0000_0100 with memory answering ack after 3 cycles, line = {4{0xA5A5_0000}} -> stall high for 5 cycles, rdata = 0xA5A5_0000, miss_cnt = 1, hit_cnt = 1, mem_we_o never high.
- Store 0x0000_0104 = 0x1234_5678 after that refill -> hit, no stall. Then load 0x0000_0104 -> 0x1234_5678 in the same cycle; hit_cnt = 3.
- Conflicting load 0x0000_1104 (same index 0, dirty):
  - WRITEBACK first: mem_we_o = 1, mem_addr_o = 0x0000_0100, mem_wdata_o[63:32] = 0x1234_5678.
  - Then REFILL: mem_addr_o = 0x0000_1100.
- Stray mem_ack_i pulse in IDLE -> no state change, no array write, counters unchanged.
- rst_i asserted during REFILL with mem_req_o high -> next cycle mem_req_o = 0, stall = 0. Re-access to the same address misses again.
- Drive 2^32 - 1 hits via force preload, then one more -> hit_cnt_o wraps to 0.
